cpm_arbiter: RTL and testbench
==============================

CPM_ARBITER -- requirements
Module: cpm_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of measurement channels.
REQ-002 Parameter T_START, default 8: maximum cycles to wait for access to fall after end_measurement is raised.
REQ-003 Parameter T_DONE, default 4095: maximum cycles to wait for access to rise after it has fallen.
REQ-004 clk_200MHz  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  N_CH  per-channel level request; held with data until the matching ack.
REQ-007 result_bus  in  22*N_CH  channel i result in bits [22*i+21:22*i].
REQ-008 ack  out  N_CH  one-cycle completion pulse to the granted channel.
REQ-009 end_measurement  out  1  drives the CPM output stage; high for the whole transfer.
REQ-010 result_for_cpm  out  22  latched result of the granted channel.
REQ-011 access  in  1  CPM output stage ready; low while busy, high when it is done or idle.
REQ-012 grant_id  out  2  index of the current or last granted channel.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 timeout_err  out  N_CH  sticky per-channel timeout flag.

Function
REQ-015 The FSM states SHALL be IDLE, GRANT, START, WAIT_DONE, ACK and HOLD.
REQ-016 IDLE: when any req bit is high and access=1, go to GRANT; while access=0, stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last grant+1) mod N_CH; after reset the pointer is N_CH-1, so channel 0 wins first.
REQ-018 GRANT (1 cycle): latch grant_id and result_for_cpm from result_bus; go to START.
REQ-019 START: end_measurement=1; when access=0, go to WAIT_DONE and clear the timer.
REQ-020 If START lasts T_START cycles with access still 1, set timeout_err[grant_id] and go to ACK.
REQ-021 WAIT_DONE: end_measurement stays 1; when access=1, go to ACK.
REQ-022 If WAIT_DONE lasts T_DONE cycles, set timeout_err[grant_id] and go to ACK.
REQ-023 ACK (1 cycle): end_measurement=0; ack[grant_id]=1, all other ack bits 0; go to HOLD.
REQ-024 HOLD (1 cycle): req is ignored, giving the channel a cycle to drop req; go to IDLE.
REQ-025 Latency from req rise (IDLE, access=1) to end_measurement=1 SHALL be 2 cycles.
REQ-026 result_for_cpm SHALL stay stable from GRANT until the next GRANT; changes on result_bus have no effect.
REQ-027 Requests arriving during a transfer SHALL be served only after HOLD, in round-robin order.
REQ-028 If req of the granted channel drops before ACK, the transfer SHALL complete and ack is still issued.
REQ-029 A single requester SHALL be re-granted after HOLD with no starvation penalty; at most 1 grant per channel per N_CH grants under full load.
REQ-030 Timer: one 12-bit saturating counter, cleared on every state entry.
REQ-031 timeout_err bits clear only on reset.

Reset
REQ-032 While reset=1 (asynchronous): state=IDLE, end_measurement=0, result_for_cpm=0, ack=0, grant_id=0, busy=0, timeout_err=0, round-robin pointer=N_CH-1, timer=0.
REQ-033 Reset asserted mid-transfer SHALL drop end_measurement immediately, with no ack; the first grant after release follows REQ-016 and REQ-017.

Structure
REQ-034 The shared package SHALL hold the state encoding, the result width (22), the default T_START/T_DONE values and the timer width (12).
REQ-035 Round-robin selection SHALL be one sub-module, rr_select (inputs: req, pointer; outputs: valid, index), which is purely combinational.
REQ-036 Synthesizable RTL SHALL be 120-400 lines in total.

Verification
REQ-037 req=0001, result0=0x2AAAA, access model falls after 1 cycle and rises 2046 cycles later -> end_measurement at +2, result_for_cpm=0x2AAAA, one ack[0] pulse, busy low 2 cycles after ack.
REQ-038 req=1111 held, with re-assert after each ack -> grant order 0,1,2,3,0; each ack matches its grant_id.
REQ-039 access stuck at 1 -> after 8 cycles in START, timeout_err[grant_id]=1, ack pulsed, next channel served.
REQ-040 access falls but never rises -> after 4095 cycles, timeout_err set and ack pulsed; flag persists until reset.
REQ-041 reset asserted 100 cycles into WAIT_DONE -> end_measurement=0 asynchronously, no ack; after release, channel 0 is granted first.
REQ-042 result_bus changed during WAIT_DONE -> result_for_cpm unchanged until the next GRANT.

Source files
------------

// File: rtl/cpm_arbiter_pkg.sv
// Shared types and constants for the CPM result arbiter.
package cpm_arbiter_pkg;

  localparam int RES_W       = 22;
  localparam int TMR_W       = 12;
  localparam int T_START_DEF = 8;
  localparam int T_DONE_DEF  = 4095;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4,
    ST_HOLD      = 3'd5
  } cpm_state_e;

  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
    return (&t) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/cpm_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after the pointer wins.
module rr_select #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [1:0]      pointer,
  output logic            valid,
  output logic [1:0]      index
);

  logic [1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = 2'((int'(pointer) + k) % N_CH);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/cpm_arbiter.sv
// Arbitrates per-channel measurement results onto the single CPM output stage.
//
// state     | meaning
// IDLE      | waiting for a request while the output stage is ready
// GRANT     | winner and its result latched
// START     | end_measurement raised, waiting for access to fall
// WAIT_DONE | output stage busy, waiting for access to rise
// ACK       | one-cycle ack to the granted channel
// HOLD      | requests ignored so the served channel can drop req
module cpm_arbiter
  import cpm_arbiter_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int T_START = T_START_DEF,
  parameter int T_DONE  = T_DONE_DEF
) (
  input  logic                  clk_200MHz,
  input  logic                  reset,
  input  logic [N_CH-1:0]       req,
  input  logic [RES_W*N_CH-1:0] result_bus,
  output logic [N_CH-1:0]       ack,
  output logic                  end_measurement,
  output logic [RES_W-1:0]      result_for_cpm,
  input  logic                  access,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic [N_CH-1:0]       timeout_err
);

  cpm_state_e       state;
  cpm_state_e       state_nxt;
  logic [TMR_W-1:0] timer;
  logic [1:0]       ptr;
  logic [1:0]       sel_index;
  logic             sel_valid;
  logic             set_to;
  logic [RES_W-1:0] chan_res [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_res
    assign chan_res[i] = result_bus[RES_W*i +: RES_W];
  end

  rr_select #(.N_CH(N_CH)) u_rr (
    .req     (req),
    .pointer (ptr),
    .valid   (sel_valid),
    .index   (sel_index)
  );

  always_ff @(posedge clk_200MHz or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      timer          <= '0;
      ptr            <= 2'(N_CH - 1);
      grant_id       <= '0;
      result_for_cpm <= '0;
      timeout_err    <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : tmr_inc(timer);
      // Winner and its data are captured on the edge into GRANT.
      if (state == ST_IDLE && state_nxt == ST_GRANT) begin
        grant_id       <= sel_index;
        ptr            <= sel_index;
        result_for_cpm <= chan_res[sel_index];
      end
      if (set_to) begin
        timeout_err[grant_id] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    set_to          = 1'b0;
    ack             = '0;
    end_measurement = 1'b0;
    busy            = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (access && sel_valid) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        state_nxt = ST_START;
      end
      ST_START: begin
        end_measurement = 1'b1;
        if (!access) begin
          state_nxt = ST_WAIT_DONE;
        end else if (timer >= TMR_W'(T_START - 1)) begin
          set_to    = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_WAIT_DONE: begin
        end_measurement = 1'b1;
        if (access) begin
          state_nxt = ST_ACK;
        end else if (timer >= TMR_W'(T_DONE - 1)) begin
          set_to    = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        ack[grant_id] = 1'b1;
        state_nxt     = ST_HOLD;
      end
      ST_HOLD: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpm_arbiter.sv
// Randomized transaction bench for cpm_arbiter against a transfer-level model.
module tb_cpm_arbiter;

  localparam int N  = 4;
  localparam int TS = 8;
  localparam int TD = 4095;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [22*N-1:0] result_bus;
  logic [N-1:0]    ack;
  logic            end_measurement;
  logic [21:0]     result_for_cpm;
  logic            access = 1'b1;
  logic [1:0]      grant_id;
  logic            busy;
  logic [N-1:0]    timeout_err;

  logic [21:0]     res_m [N];
  logic [N-1:0]    pending = '0;
  logic [1:0]      ptr_m = 2'(N - 1);
  logic [N-1:0]    to_m = '0;
  int              checks = 0;
  int              failures = 0;

  for (genvar g = 0; g < N; g++) begin : g_bus
    assign result_bus[22*g +: 22] = res_m[g];
  end

  cpm_arbiter #(.N_CH(N), .T_START(TS), .T_DONE(TD)) dut (
    .clk_200MHz      (clk),
    .reset           (reset),
    .req             (req),
    .result_bus      (result_bus),
    .ack             (ack),
    .end_measurement (end_measurement),
    .result_for_cpm  (result_for_cpm),
    .access          (access),
    .grant_id        (grant_id),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [N-1:0] pend, input logic [1:0] last);
    logic [1:0] c;
    for (int k = 1; k <= N; k++) begin
      c = 2'((int'(last) + k) % N);
      if (pend[c]) return c;
    end
    return 2'd0;
  endfunction

  // access seen by the arbiter t cycles after START entry:
  // high for f cycles, low for one cycle plus r more, then high.
  function automatic logic sched(input int t, input int f, input int r);
    if (f >= TS) return 1'b1;
    if (t < f) return 1'b1;
    if (t < f + 1 + r) return 1'b0;
    return 1'b1;
  endfunction

  task automatic randomize_bus();
    for (int i = 0; i < N; i++) res_m[i] = 22'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_trn(input logic [N-1:0] new_req, input bit exact, input int f, input int r,
                         input bit noise, input bit use_res0, input logic [21:0] res0);
    logic [1:0]   exp;
    logic [1:0]   ch;
    logic [21:0]  exp_res;
    logic [N-1:0] exp_ack;
    int           pred;
    int           t;
    int           idle_wait;
    bit           to_flag;

    if (exact) pending = new_req;
    else       pending |= new_req;
    if (pending == '0) begin
      ch = 2'($urandom_range(N - 1, 0));
      pending[ch] = 1'b1;
    end
    randomize_bus();
    if (use_res0) res_m[0] = res0;
    req = pending;
    if (noise) begin
      idle_wait = int'($urandom_range(2, 0));
      access = 1'b0;
      repeat (idle_wait) begin
        step();
        check_val("idle_no_access", 32'(busy), 0);
      end
    end
    access = 1'b1;

    exp     = pick(pending, ptr_m);
    exp_res = res_m[exp];
    step();
    check_val("grant_id", 32'(grant_id), 32'(exp));
    check_val("grant_busy", 32'(busy), 1);
    check_val("grant_endm", 32'(end_measurement), 0);
    ptr_m = exp;
    step();
    check_val("start_endm", 32'(end_measurement), 1);
    check_val("start_result", 32'(result_for_cpm), 32'(exp_res));

    to_flag = (f >= TS) || (r >= TD);
    pred    = (f >= TS) ? TS : f + 1 + ((r < TD - 1) ? r : TD - 1) + 1;
    for (t = 1; t <= pred + 16; t++) begin
      access = sched(t - 1, f, r);
      if (noise) begin
        randomize_bus();
        if ($urandom_range(7, 0) == 0) begin
          ch = 2'($urandom_range(N - 1, 0));
          pending[ch] = 1'b1;
        end
        if ($urandom_range(15, 0) == 0) pending[exp] = 1'b0;
        req = pending;
      end else begin
        res_m[exp] = ~exp_res;
      end
      step();
      if (ack != '0) break;
      check_val("xfer_endm", 32'(end_measurement), 1);
    end
    exp_ack      = '0;
    exp_ack[exp] = 1'b1;
    if (to_flag) to_m[exp] = 1'b1;
    check_val("ack_latency", t, pred);
    check_val("ack_onehot", 32'(ack), 32'(exp_ack));
    check_val("ack_endm", 32'(end_measurement), 0);
    check_val("ack_result", 32'(result_for_cpm), 32'(exp_res));
    check_val("timeout_err", 32'(timeout_err), 32'(to_m));

    pending[exp] = 1'b0;
    req    = pending;
    access = 1'b1;
    step();
    check_val("hold_ack", 32'(ack), 0);
    check_val("hold_busy", 32'(busy), 1);
    step();
    check_val("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [1:0] exp;
    bit         saw_ack;

    randomize_bus();
    repeat (3) step();
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_endm", 32'(end_measurement), 0);
    check_val("rst_ack", 32'(ack), 0);
    check_val("rst_grant", 32'(grant_id), 0);
    check_val("rst_result", 32'(result_for_cpm), 0);
    check_val("rst_timeout", 32'(timeout_err), 0);
    reset = 1'b0;

    // Full load, re-asserted after every ack: expect grants 0,1,2,3,0.
    repeat (5) run_trn(4'hF, 1'b1, 2, 3, 1'b0, 1'b0, 22'h0);

    // Single requester, long output-stage transfer.
    run_trn(4'b0001, 1'b1, 1, 2046, 1'b0, 1'b1, 22'h2AAAA);

    // access stuck high: START timeout, then the other requester is served.
    run_trn(4'b0011, 1'b1, TS + 4, 0, 1'b0, 1'b0, 22'h0);
    run_trn(4'b0000, 1'b0, 0, 2, 1'b0, 1'b0, 22'h0);

    // access falls and never rises: WAIT_DONE timeout.
    run_trn(4'b0100, 1'b1, 0, TD + 100, 1'b0, 1'b0, 22'h0);

    for (int i = 0; i < 40; i++) begin
      run_trn(4'($urandom_range(15, 0)), 1'b0, int'($urandom_range(TS + 1, 0)),
              int'($urandom_range(40, 0)), 1'b1, 1'b0, 22'h0);
    end

    // Reset asserted 100 cycles into WAIT_DONE.
    pending = 4'b1000;
    req     = pending;
    access  = 1'b1;
    exp     = pick(pending, ptr_m);
    step();
    check_val("mid_grant", 32'(grant_id), 32'(exp));
    step();
    access = 1'b0;
    step();
    saw_ack = 1'b0;
    repeat (100) begin
      step();
      if (ack != '0) saw_ack = 1'b1;
    end
    check_val("mid_endm_pre", 32'(end_measurement), 1);
    #3;
    reset = 1'b1;
    #1;
    check_val("mid_rst_endm", 32'(end_measurement), 0);
    check_val("mid_rst_ack", 32'(ack), 0);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_result", 32'(result_for_cpm), 0);
    check_val("mid_rst_timeout", 32'(timeout_err), 0);
    check_val("mid_no_ack", 32'(saw_ack), 0);
    ptr_m  = 2'(N - 1);
    to_m   = '0;
    access = 1'b1;
    step();
    reset = 1'b0;
    run_trn(4'hF, 1'b1, 2, 3, 1'b0, 1'b0, 22'h0);
    run_trn(4'h0, 1'b0, 3, 5, 1'b0, 1'b0, 22'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
